// File: rtl/loop_act_capture.sv
// Pass-end capture stage: snapshots act1/act2 totals into a 2-entry valid/ready record FIFO.
// Define LOOP_ACT_CHECK_EN to compile in the expected-total comparator and err_cnt.
module loop_act_capture #(
    parameter logic [7:0] EXP_ACT1 = 8'd10,
    parameter logic [7:0] EXP_ACT2 = 8'd100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  phase_in,
    input  logic [7:0]  act1_in,
    input  logic [7:0]  act2_in,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [7:0]  rec_act1,
    output logic [7:0]  rec_act2,
    output logic [7:0]  rec_pass_id,
    output logic        rec_err,
    output logic [15:0] pass_cnt,
    output logic [7:0]  err_cnt,
    output logic [7:0]  drop_cnt,
    output logic        ovf
);

    logic [1:0] phase_d;
    logic       pe;
    logic       err;
    logic       push;
    logic       pop;
    logic       drop;
    logic [7:0] pid;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    logic [7:0] mem_act1 [2];
    logic [7:0] mem_act2 [2];
    logic [7:0] mem_pid  [2];
    logic       mem_err  [2];

    assign pe = (phase_in == 2'd1) && (phase_d != 2'd1);

`ifdef LOOP_ACT_CHECK_EN
    assign err = (act1_in != EXP_ACT1) || (act2_in != EXP_ACT2);
`else
    // Comparator removed; the reduction keeps the expected totals referenced but is constant 0.
    assign err = &{1'b0, EXP_ACT1, EXP_ACT2};
`endif

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign rec_valid = (count != 2'd0);
    assign pop       = rec_valid && rec_ready;
    assign push      = pe && ((count < 2'd2) || pop);
    assign drop      = pe && !push;

    assign rec_act1    = mem_act1[rd_ptr];
    assign rec_act2    = mem_act2[rd_ptr];
    assign rec_pass_id = mem_pid[rd_ptr];
    assign rec_err     = mem_err[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_d  <= 2'd0;
            pid      <= 8'd0;
            pass_cnt <= 16'd0;
            drop_cnt <= 8'd0;
            ovf      <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_act1[i] <= 8'd0;
                mem_act2[i] <= 8'd0;
                mem_pid[i]  <= 8'd0;
                mem_err[i]  <= 1'b0;
            end
        end else begin
            phase_d <= phase_in;
            if (pe) begin
                pass_cnt <= pass_cnt + 16'd1;
                pid      <= pid + 8'd1;
            end
            if (push) begin
                mem_act1[wr_ptr] <= act1_in;
                mem_act2[wr_ptr] <= act2_in;
                mem_pid[wr_ptr]  <= pid;
                mem_err[wr_ptr]  <= err;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
            if (drop) begin
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
                ovf <= 1'b1;
            end
        end
    end

`ifdef LOOP_ACT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (pe && err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_loop_act_capture.sv
// Testbench for loop_act_capture: a fixed vector table, corner-case sequences and
// randomized traffic checked against a queue-based record model.
module tb_loop_act_capture;

`ifdef LOOP_ACT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  phase_in = 2'd0;
    logic [7:0]  act1_in = 8'd0;
    logic [7:0]  act2_in = 8'd0;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [7:0]  rec_act1;
    logic [7:0]  rec_act2;
    logic [7:0]  rec_pass_id;
    logic        rec_err;
    logic [15:0] pass_cnt;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    loop_act_capture dut (
        .clk(clk), .rst_n(rst_n), .phase_in(phase_in), .act1_in(act1_in), .act2_in(act2_in),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_act1(rec_act1), .rec_act2(rec_act2),
        .rec_pass_id(rec_pass_id), .rec_err(rec_err), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
        .drop_cnt(drop_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] pid;
        logic       er;
    } rec_t;

    // Reference model: records waiting for the consumer, plus observation counters.
    rec_t        m_q[$];
    logic [1:0]  m_phase_d;
    logic [7:0]  m_pid;
    logic [15:0] m_pass;
    int          m_err_cnt;
    int          m_drop;
    logic        m_ovf;

    typedef struct {
        logic [1:0]  ph;
        logic [7:0]  a1;
        logic [7:0]  a2;
        logic        rdy;
        logic        v;
        logic [7:0]  e1;
        logic [7:0]  e2;
        logic [7:0]  pid;
        logic        er;
        logic [15:0] pc;
        logic [7:0]  dc;
        logic        ov;
        logic [7:0]  ec;
    } vec_t;

    vec_t vecs[12];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase_d = 2'd0;
        m_pid     = 8'd0;
        m_pass    = 16'd0;
        m_err_cnt = 0;
        m_drop    = 0;
        m_ovf     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        phase_in  = 2'd0;
        act1_in   = 8'd0;
        act2_in   = 8'd0;
        rec_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one cycle of inputs, advances the model, and returns just after the edge.
    task automatic applyStimulus(input logic [1:0] ph, input logic [7:0] a1, input logic [7:0] a2,
                                 input logic rdy);
        rec_t r;
        bit   pe;
        @(negedge clk);
        phase_in  = ph;
        act1_in   = a1;
        act2_in   = a2;
        rec_ready = rdy;
        pe = (ph == 2'd1) && (m_phase_d != 2'd1);
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (pe) begin
            r.a1  = a1;
            r.a2  = a2;
            r.pid = m_pid;
            r.er  = CHK && ((a1 != 8'd10) || (a2 != 8'd100));
            if (m_q.size() < 2) begin
                m_q.push_back(r);
            end else begin
                if (m_drop < 255) m_drop++;
                m_ovf = 1'b1;
            end
            m_pid  = m_pid + 8'd1;
            m_pass = m_pass + 16'd1;
            if (r.er && m_err_cnt < 255) m_err_cnt++;
        end
        m_phase_d = ph;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        check_val("rec_valid", rec_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check_val("rec_act1", rec_act1, m_q[0].a1);
            check_val("rec_act2", rec_act2, m_q[0].a2);
            check_val("rec_pass_id", rec_pass_id, m_q[0].pid);
            check_val("rec_err", rec_err, m_q[0].er);
        end
        check_val("pass_cnt", pass_cnt, m_pass);
        check_val("err_cnt", err_cnt, m_err_cnt);
        check_val("drop_cnt", drop_cnt, m_drop);
        check_val("ovf", ovf, m_ovf);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"}, rec_valid, 0);
        check_val({tag, "_act1"}, rec_act1, 0);
        check_val({tag, "_act2"}, rec_act2, 0);
        check_val({tag, "_pid"}, rec_pass_id, 0);
        check_val({tag, "_err"}, rec_err, 0);
        check_val({tag, "_pass_cnt"}, pass_cnt, 0);
        check_val({tag, "_err_cnt"}, err_cnt, 0);
        check_val({tag, "_drop_cnt"}, drop_cnt, 0);
        check_val({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        // phase, act1, act2, ready | valid, act1, act2, pid, err, pass_cnt, drop_cnt, ovf, err_cnt
        vecs[0]  = '{2'd0, 8'd0,  8'd0,   1'b0, 1'b0, 8'd0,  8'd0,   8'd0, 1'b0, 16'd0, 8'd0, 1'b0, 8'd0};
        vecs[1]  = '{2'd1, 8'd10, 8'd100, 1'b0, 1'b1, 8'd10, 8'd100, 8'd0, 1'b0, 16'd1, 8'd0, 1'b0, 8'd0};
        vecs[2]  = '{2'd1, 8'd10, 8'd100, 1'b0, 1'b1, 8'd10, 8'd100, 8'd0, 1'b0, 16'd1, 8'd0, 1'b0, 8'd0};
        vecs[3]  = '{2'd0, 8'd0,  8'd0,   1'b0, 1'b1, 8'd10, 8'd100, 8'd0, 1'b0, 16'd1, 8'd0, 1'b0, 8'd0};
        vecs[4]  = '{2'd1, 8'd11, 8'd101, 1'b0, 1'b1, 8'd10, 8'd100, 8'd0, 1'b0, 16'd2, 8'd0, 1'b0, CHK ? 8'd1 : 8'd0};
        vecs[5]  = '{2'd2, 8'd0,  8'd0,   1'b0, 1'b1, 8'd10, 8'd100, 8'd0, 1'b0, 16'd2, 8'd0, 1'b0, CHK ? 8'd1 : 8'd0};
        vecs[6]  = '{2'd1, 8'd12, 8'd102, 1'b0, 1'b1, 8'd10, 8'd100, 8'd0, 1'b0, 16'd3, 8'd1, 1'b1, CHK ? 8'd2 : 8'd0};
        vecs[7]  = '{2'd0, 8'd0,  8'd0,   1'b1, 1'b1, 8'd11, 8'd101, 8'd1, CHK,  16'd3, 8'd1, 1'b1, CHK ? 8'd2 : 8'd0};
        vecs[8]  = '{2'd1, 8'd13, 8'd103, 1'b1, 1'b1, 8'd13, 8'd103, 8'd3, CHK,  16'd4, 8'd1, 1'b1, CHK ? 8'd3 : 8'd0};
        vecs[9]  = '{2'd0, 8'd0,  8'd0,   1'b1, 1'b0, 8'd0,  8'd0,   8'd0, 1'b0, 16'd4, 8'd1, 1'b1, CHK ? 8'd3 : 8'd0};
        vecs[10] = '{2'd3, 8'd0,  8'd0,   1'b1, 1'b0, 8'd0,  8'd0,   8'd0, 1'b0, 16'd4, 8'd1, 1'b1, CHK ? 8'd3 : 8'd0};
        vecs[11] = '{2'd1, 8'd9,  8'd100, 1'b0, 1'b1, 8'd9,  8'd100, 8'd4, CHK,  16'd5, 8'd1, 1'b1, CHK ? 8'd4 : 8'd0};

        do_reset();
        check_reset_state("reset");

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].ph, vecs[i].a1, vecs[i].a2, vecs[i].rdy);
            check_val("tbl_valid", rec_valid, vecs[i].v);
            if (vecs[i].v) begin
                check_val("tbl_act1", rec_act1, vecs[i].e1);
                check_val("tbl_act2", rec_act2, vecs[i].e2);
                check_val("tbl_pid", rec_pass_id, vecs[i].pid);
                check_val("tbl_err", rec_err, vecs[i].er);
            end
            check_val("tbl_pass_cnt", pass_cnt, vecs[i].pc);
            check_val("tbl_drop_cnt", drop_cnt, vecs[i].dc);
            check_val("tbl_ovf", ovf, vecs[i].ov);
            check_val("tbl_err_cnt", err_cnt, vecs[i].ec);
        end

        // Full FIFO with a pop on the pass-end cycle: nothing dropped, ids stay in order.
        do_reset();
        applyStimulus(2'd1, 8'd10, 8'd100, 1'b0);
        applyStimulus(2'd0, 8'd0, 8'd0, 1'b0);
        applyStimulus(2'd1, 8'd10, 8'd100, 1'b0);
        applyStimulus(2'd0, 8'd0, 8'd0, 1'b0);
        applyStimulus(2'd1, 8'd10, 8'd100, 1'b1);
        checkOutput();
        check_val("full_pop_drop", drop_cnt, 0);
        check_val("full_pop_head", rec_pass_id, 1);
        applyStimulus(2'd0, 8'd0, 8'd0, 1'b1);
        check_val("full_pop_head2", rec_pass_id, 2);
        checkOutput();
        applyStimulus(2'd0, 8'd0, 8'd0, 1'b1);
        check_val("full_pop_empty", rec_valid, 0);

        // Phase 1 held for several cycles yields a single record.
        do_reset();
        for (int i = 0; i < 5; i++) applyStimulus(2'd1, 8'd10, 8'd100, 1'b0);
        applyStimulus(2'd2, 8'd0, 8'd0, 1'b0);
        check_val("hold_pass_cnt", pass_cnt, 1);
        applyStimulus(2'd0, 8'd0, 8'd0, 1'b1);
        check_val("hold_one_record", rec_valid, 0);
        checkOutput();

        // Asynchronous reset with two records buffered.
        applyStimulus(2'd1, 8'd10, 8'd100, 1'b0);
        applyStimulus(2'd0, 8'd0, 8'd0, 1'b0);
        applyStimulus(2'd1, 8'd7, 8'd100, 1'b0);
        checkOutput();
        #1 rst_n = 1'b0;
        #1 check_reset_state("async_rst");
        model_reset();
        phase_in = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'd1, 8'd10, 8'd100, 1'b1);
        check_val("post_rst_pid", rec_pass_id, 0);
        checkOutput();

        // Many passes with no consumer: drop_cnt and err_cnt saturate, pid wraps.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            applyStimulus(2'd1, 8'd1, 8'd100, 1'b0);
            applyStimulus(2'd0, 8'd0, 8'd0, 1'b0);
        end
        check_val("sat_drop_cnt", drop_cnt, 255);
        check_val("sat_err_cnt", err_cnt, CHK ? 255 : 0);
        check_val("sat_pass_cnt", pass_cnt, 260);
        checkOutput();
        applyStimulus(2'd1, 8'd10, 8'd100, 1'b1);
        checkOutput();
        applyStimulus(2'd0, 8'd0, 8'd0, 1'b1);
        checkOutput();
        check_val("wrap_pid", rec_pass_id, 8'd4);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] a1;
            logic [7:0] a2;
            a1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd10;
            a2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd100;
            applyStimulus(2'($urandom_range(0, 3)), a1, a2, 1'($urandom));
            checkOutput();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loop_act_capture.md
# loop_act_capture

Downstream capture stage for the nested-loop action engine. Watches the engine's phase and action counters, snapshots the final `act1`/`act2` totals at the end of every pass, and optionally checks them against expected values. Buffers snapshots in a 2-entry FIFO and presents them on a valid/ready record port, with pass, error and drop counters for observation.

## Interface
Parameters:
- `EXP_ACT1`, 8'd10: expected outer-action total per pass.
- `EXP_ACT2`, 8'd100: expected inner-action total per pass.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `phase_in`  in  2  engine state; 0 = counting, 1 = pass-end/clear, 2–3 = not a pass end.
- `act1_in`  in  8  engine outer-action counter.
- `act2_in`  in  8  engine inner-action counter.
- `rec_valid`  out  1  FIFO head holds a record.
- `rec_ready`  in  1  consumer accepts the head record.
- `rec_act1`  out  8  head record act1 total.
- `rec_act2`  out  8  head record act2 total.
- `rec_pass_id`  out  8  head record pass number, wraps 255→0.
- `rec_err`  out  1  head record mismatched expected totals.
- `pass_cnt`  out  16  passes detected, wraps.
- `err_cnt`  out  8  mismatching passes, saturates at 255.
- `drop_cnt`  out  8  passes dropped on full FIFO, saturates at 255.
- `ovf`  out  1  sticky: at least one drop since reset.

## Operation
- `phase_d` registers `phase_in`. Pass end (`pe`) = `phase_in==1 && phase_d!=1`. One `pe` per entry into phase 1. Phase 1 held for several cycles yields one `pe`. Values 2/3 never produce `pe`.
- On `pe`, record = {`act1_in`, `act2_in`, `pid`, `err`}. Here `pid` is the internal pass id, and `err` = (`act1_in`!=`EXP_ACT1`) || (`act2_in`!=`EXP_ACT2`).
- On `pe`:
  - `pass_cnt` +1 (16-bit wrap).
  - `pid` +1 (8-bit wrap).
  - `err_cnt` +1 if `err`, saturating.
- These updates happen whether or not the record is stored.
- FIFO:
  - 2 entries, write pointer, read pointer, 2-bit count.
  - Push on `pe` if count<2, or if count==2 and a pop occurs in the same cycle (pop-before-push).
  - Otherwise the record is dropped: `drop_cnt` +1 (saturating) and `ovf` set until reset.
- Pop when `rec_valid && rec_ready`. `rec_ready` while `rec_valid`=0 has no effect.
- The `rec_*` data outputs always show the head entry. They are held stable while `rec_valid && !rec_ready`.
- Simultaneous push and pop:
  - count 1: count stays 1, the new record becomes head next cycle.
  - count 2: count stays 2.
  - count 0: no pop, push only.
- Reset values: `rec_valid`=0, `rec_act1`=0, `rec_act2`=0, `rec_pass_id`=0, `rec_err`=0, `pass_cnt`=0, `err_cnt`=0, `drop_cnt`=0, `ovf`=0. Internal: `pid`=0, `phase_d`=0, pointers and count=0.
- Reset mid-operation clears all buffered records immediately (asynchronous). No `pe` is generated on the first cycle after reset unless `phase_in`==1 on that edge (`phase_d`=0).

## Timing
- `pe` is combinational from `phase_in` and `phase_d`. Capture happens on the same rising edge where `phase_in`==1 is first sampled.
- Latency: record pushed at edge N → `rec_valid`=1 and data valid after edge N (visible in cycle N+1). There is no combinational bypass from `act*_in` to `rec_*`.
- Counters (`pass_cnt`, `err_cnt`, `drop_cnt`, `ovf`) update on the same edge as the capture.
- Pop at edge M → the next entry (if any) is presented after edge M. Back-to-back pops, one per cycle, are supported.
- `act1_in`/`act2_in` are sampled only on the `pe` edge. The engine must present final totals during its first phase-1 cycle.

## Configuration
- `LOOP_ACT_CHECK_EN` defined: expected-value comparison compiled in. `rec_err` and `err_cnt` behave as above.
- Not defined: comparator and `err_cnt` register removed. `err` is forced 0, `rec_err`=0 and `err_cnt`=0 permanently. All other behaviour, including the FIFO and drop logic, is unchanged.

## Test plan
- Reset, drive one pass with act1=10, act2=100, `rec_ready`=1 → one `rec_valid` pulse with act1=10, act2=100, pass_id=0, err=0; `pass_cnt`=1, `err_cnt`=0.
- Pass with act1=9, act2=100 (check enabled) → `rec_err`=1, `err_cnt`=1. With the macro undefined → `rec_err`=0, `err_cnt`=0.
- `rec_ready`=0, three passes → `rec_valid` held; head pass_id=0, then 1 after a pop; `drop_cnt`=1, `ovf`=1, `pass_cnt`=3.
- FIFO full with `rec_ready`=1 on the same cycle as `pe` → no drop; count stays 2; records emerge in order with pass_ids 0, 1, 2.
- Hold `phase_in`=1 for 5 cycles, then pulse `phase_in`=2 → exactly one record; `pass_cnt`=1.
- Assert `rst_n`=0 with 2 records buffered → `rec_valid`=0 and all counters 0 immediately. A pass after release → pass_id=0.
